// File: rtl/ivector_arb_pkg.sv
// Shared types, default parameters and width helpers for the ivector_arb block.
package ivector_pkg;

  localparam int NCHAN_DEF = 4;
  localparam int MW_DEF    = 32;
  localparam int VW_DEF    = 32;
  localparam int DEPTH_DEF = 8;

  function automatic int chan_w(input int nchan);
    return (nchan <= 1) ? 1 : $clog2(nchan);
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int CW_DEF = chan_w(NCHAN_DEF);
  localparam int AW_DEF = addr_w(DEPTH_DEF);

  typedef struct packed {
    logic [CW_DEF-1:0] chan;
    logic [MW_DEF-1:0] meth;
    logic [VW_DEF-1:0] v;
  } ivector_entry_t;

endpackage

// File: rtl/ivector_arb_if.sv
// say() request bundle and heard() indication bundle; master is the host side, slave the arbiter.
interface ivector_arb_if
  import ivector_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF,
  parameter int MW    = MW_DEF,
  parameter int VW    = VW_DEF
);
  localparam int CW = chan_w(NCHAN);

  logic [NCHAN-1:0]    say_ena;
  logic [NCHAN*MW-1:0] say_meth;
  logic [NCHAN*VW-1:0] say_v;
  logic [NCHAN-1:0]    say_rdy;

  logic                heard_ena;
  logic [MW-1:0]       heard_meth;
  logic [VW-1:0]       heard_v;
  logic [CW-1:0]       heard_chan;
  logic                heard_rdy;

  modport master (
    output say_ena, say_meth, say_v, heard_rdy,
    input  say_rdy, heard_ena, heard_meth, heard_v, heard_chan
  );

  modport slave (
    input  say_ena, say_meth, say_v, heard_rdy,
    output say_rdy, heard_ena, heard_meth, heard_v, heard_chan
  );
endinterface

// File: rtl/ivector_arb_fifo.sv
// Generic DEPTH-entry FIFO with wrap-bit pointers; occupancy count present with IVECTOR_VSIZE_EN.
module ivector_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enq_i,
  input  logic [W-1:0] enq_data_i,
  input  logic         deq_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
`ifdef IVECTOR_VSIZE_EN
  ,
  output logic [AW:0]  count_o
`endif
);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (enq_i) wr_d = wr_q + 1'b1;
    if (deq_i) rd_d = rd_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_q[AW-1:0]] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

`ifdef IVECTOR_VSIZE_EN
  logic [AW:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= wr_d - rd_d;
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/ivector_arb.sv
// Multi-channel say() arbiter: round-robin token picks the channel, one shared FIFO feeds heard().
// Optional occupancy port vsize is enabled by defining IVECTOR_VSIZE_EN.
module ivector_arb
  import ivector_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF,
  parameter int MW    = MW_DEF,
  parameter int VW    = VW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic CLK,
  input  logic RST,
  ivector_arb_if.slave bus
`ifdef IVECTOR_VSIZE_EN
  ,
  output logic [$clog2(DEPTH):0] vsize
`endif
);

  localparam int CW = chan_w(NCHAN);
  localparam int AW = addr_w(DEPTH);

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [MW-1:0] meth;
    logic [VW-1:0] v;
  } entry_t;

  logic [CW-1:0] tok_q, tok_d;
  logic          full, empty, enq, deq;
  entry_t        wr_entry, head;

  // Token moves every cycle whether or not anyone talks, so each channel gets a slot every NCHAN cycles.
  assign tok_d = (tok_q == CW'(NCHAN - 1)) ? '0 : tok_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) tok_q <= '0;
    else     tok_q <= tok_d;
  end

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bus.say_rdy = '0;
    if (!full) bus.say_rdy[tok_q] = 1'b1;
  end

  assign enq = bus.say_ena[tok_q] & ~full;
  assign deq = ~empty & bus.heard_rdy;

  assign wr_entry.chan = tok_q;
  assign wr_entry.meth = bus.say_meth[tok_q*MW +: MW];
  assign wr_entry.v    = bus.say_v[tok_q*VW +: VW];

  ivector_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .enq_i      (enq),
    .enq_data_i (wr_entry),
    .deq_i      (deq),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
`ifdef IVECTOR_VSIZE_EN
    ,
    .count_o    (vsize)
`endif
  );

  assign bus.heard_ena  = deq;
  assign bus.heard_meth = head.meth;
  assign bus.heard_v    = head.v;
  assign bus.heard_chan = head.chan;

  a_ena_only_when_ready: assert property (
    @(posedge CLK) disable iff (RST) (bus.say_ena & ~bus.say_rdy) == '0
  );

endmodule

// File: tb/tb_ivector_arb.sv
// Directed + randomized bench for ivector_arb against a queue-based reference model.
module tb_ivector_arb;
  import ivector_pkg::*;

  localparam int NCHAN = NCHAN_DEF;
  localparam int MW    = MW_DEF;
  localparam int VW    = VW_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ivector_arb_if #(.NCHAN(NCHAN), .MW(MW), .VW(VW)) bus ();
`ifdef IVECTOR_VSIZE_EN
  logic [AW_DEF:0] vsize;
`endif

  ivector_arb #(.NCHAN(NCHAN), .MW(MW), .VW(VW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef IVECTOR_VSIZE_EN
    ,
    .vsize (vsize)
`endif
  );

  // Reference model: cycles since reset decide the token, a queue holds the messages.
  ivector_entry_t q[$];
  int  cyc    = 0;
  bit  mvalid = 1'b0;
  int  nacc   = 0;
  int  ncmp   = 0;
  int  nfail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCHAN-1:0] mrdy();
    if (q.size() >= DEPTH) return '0;
    return NCHAN'(1) << (cyc % NCHAN);
  endfunction

  task automatic set_say(input logic [NCHAN-1:0] ena);
    bus.say_ena = ena;
    for (int i = 0; i < NCHAN; i++) begin
      bus.say_meth[i*MW +: MW] = $urandom;
      bus.say_v[i*VW +: VW]    = $urandom;
    end
  endtask

  task automatic tick();
    logic [NCHAN-1:0] er;
    bit               fire, acc;
    int               c;
    ivector_entry_t   ne;
    @(negedge clk);
    er   = mrdy();
    fire = (q.size() != 0) && bus.heard_rdy;
    c    = cyc % NCHAN;
    if (mvalid) begin
      check("say_rdy", bus.say_rdy, er);
      check("heard_ena", bus.heard_ena, fire);
      if (fire) begin
        check("heard_meth", bus.heard_meth, q[0].meth);
        check("heard_v", bus.heard_v, q[0].v);
        check("heard_chan", bus.heard_chan, q[0].chan);
      end
`ifdef IVECTOR_VSIZE_EN
      check("vsize", vsize, q.size());
`endif
    end
    acc = mvalid && bus.say_ena[c] && er[c];
    ne  = '{chan: CW_DEF'(c), meth: bus.say_meth[c*MW +: MW], v: bus.say_v[c*VW +: VW]};
    @(posedge clk);
    if (rst) begin
      q.delete();
      cyc    = 0;
      mvalid = 1'b1;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        q.push_back(ne);
        nacc++;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic fill(input int n);
    int start;
    start = nacc;
    for (int i = 0; i < 16 * n + 16 && (nacc - start) < n; i++) begin
      set_say(mrdy());
      tick();
    end
    set_say('0);
    check("fill_count", nacc - start, n);
  endtask

  logic [NCHAN-1:0] rot [4];

  initial begin
    int start;
    rst           = 1'b1;
    bus.heard_rdy = 1'b1;
    set_say('0);

    // T1: reset, then the token walks through every channel
    tick();
    tick();
    rst = 1'b0;
    check("t1_rdy_reset", bus.say_rdy, 4'b0001);
    check("t1_heard_ena_reset", bus.heard_ena, 1'b0);
    rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_rdy_rotate", bus.say_rdy, rot[i]);
    end

    // T2: single message on channel 2
    for (int i = 0; i < 8 && (cyc % NCHAN) != 2; i++) tick();
    set_say(4'b0100);
    bus.say_meth[2*MW +: MW] = 32'd5;
    bus.say_v[2*VW +: VW]    = 32'hAB;
    tick();
    set_say('0);
    check("t2_ena", bus.heard_ena, 1'b1);
    check("t2_meth", bus.heard_meth, 32'd5);
    check("t2_v", bus.heard_v, 32'hAB);
    check("t2_chan", bus.heard_chan, 2'd2);
    tick();
    check("t2_drained", bus.heard_ena, 1'b0);

    // T3: fill with the sink stalled
    bus.heard_rdy = 1'b0;
    fill(DEPTH);
    check("t3_rdy_full", bus.say_rdy, '0);
`ifdef IVECTOR_VSIZE_EN
    check("t3_vsize_full", vsize, DEPTH);
`endif

    // T4: one deq while full; ready is withheld that cycle and returns the next
    bus.heard_rdy = 1'b1;
    set_say('1 & mrdy());
    tick();
    set_say('0);
    bus.heard_rdy = 1'b0;
    check("t4_rdy_back", bus.say_rdy != '0, 1'b1);
`ifdef IVECTOR_VSIZE_EN
    check("t4_vsize", vsize, DEPTH - 1);
`endif

    // T3 continued: drain the rest in accept order
    bus.heard_rdy = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    check("t3_empty_after_drain", bus.heard_ena, 1'b0);

    // T5: simultaneous enq+deq at occupancy 3, then random traffic
    bus.heard_rdy = 1'b0;
    fill(3);
    bus.heard_rdy = 1'b1;
    start = nacc;
    set_say(mrdy());
    tick();
    set_say('0);
    bus.heard_rdy = 1'b0;
    check("t5_concurrent_accept", nacc - start, 1);
`ifdef IVECTOR_VSIZE_EN
    check("t5_vsize_steady", vsize, 3);
`endif
    start = nacc;
    for (int i = 0; i < 600 && (nacc - start) < 20; i++) begin
      set_say($urandom_range(0, 1) ? mrdy() : '0);
      bus.heard_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    set_say('0);
    check("t5_random_count", nacc - start, 20);
    bus.heard_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("t5_empty_after_drain", bus.heard_ena, 1'b0);

    // T6: reset with 5 entries queued discards them
    bus.heard_rdy = 1'b0;
    fill(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.heard_rdy = 1'b1;
    check("t6_heard_ena", bus.heard_ena, 1'b0);
    check("t6_rdy", bus.say_rdy, 4'b0001);
`ifdef IVECTOR_VSIZE_EN
    check("t6_vsize", vsize, 0);
`endif
    set_say(mrdy());
    tick();
    set_say('0);
    check("t6_say_works", bus.heard_ena, 1'b1);
    check("t6_chan", bus.heard_chan, 2'd0);
    tick();
    check("t6_empty", bus.heard_ena, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
